// File: rtl/acondicionador_botones_if.sv
// Pushbutton bundle: raw active-low buttons in, conditioned active-low pulses
// and debounced held state out.
interface acondicionador_botones_if;
  logic [3:0] btn_n;
  logic       incrementar;
  logic       decrementar;
  logic       cambiar;
  logic       establecer;
  logic [3:0] pressed;

  modport master (
    output btn_n,
    input  incrementar, decrementar, cambiar, establecer, pressed
  );

  modport slave (
    input  btn_n,
    output incrementar, decrementar, cambiar, establecer, pressed
  );
endinterface

// File: rtl/acondicionador_botones.sv
// Button conditioner: synchronizes and debounces four raw buttons, emits one
// press pulse per accepted press and auto-repeats incrementar/decrementar.
module acondicionador_botones #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int REPEAT_CYCLES   = 3
) (
  input logic                     clk,
  input logic                     reset,
  acondicionador_botones_if.slave bus
);

  localparam int DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  // Spacings below 2 would let consecutive pulses merge into one low level.
  localparam int HOLD_EFF = (HOLD_CYCLES   < 2) ? 2 : HOLD_CYCLES;
  localparam int REP_EFF  = (REPEAT_CYCLES < 2) ? 2 : REPEAT_CYCLES;
  localparam int TMAX     = (HOLD_EFF > REP_EFF) ? HOLD_EFF : REP_EFF;
  localparam int TW       = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rep_state_e;

  logic [3:0]      sync1_q;
  logic [3:0]      sync2_q;
  logic [DB_W-1:0] cnt_q [4];
  logic [DB_W-1:0] cnt_d [4];
  logic [3:0]      stable_q;
  logic [3:0]      stable_d;
  logic [3:0]      prev_q;
  logic [3:0]      press_s;
  logic            both_s;
  rep_state_e      state_q [2];
  logic [TW-1:0]   tmr_q [2];
  logic [1:0]      rep_n_q;
  logic [1:0]      sel_n_q;

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    sat_inc = (v == TW'(TMAX)) ? v : v + TW'(1);
  endfunction

  assign press_s = stable_q & ~prev_q;
  assign both_s  = stable_q[0] & stable_q[1];

  // Debounce: a level different from the stable state must persist to be accepted
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      if (sync2_q[b] == stable_q[b]) begin
        if (cnt_q[b] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          cnt_d[b]    = '0;
          stable_d[b] = ~stable_q[b];
        end else begin
          cnt_d[b]    = cnt_q[b] + DB_W'(1);
          stable_d[b] = stable_q[b];
        end
      end else begin
        cnt_d[b]    = '0;
        stable_d[b] = stable_q[b];
      end
    end
  end

  // Synchronizer, debounce state and press-edge history
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 4'hF;
      sync2_q  <= 4'hF;
      stable_q <= 4'h0;
      prev_q   <= 4'h0;
      for (int b = 0; b < 4; b++) begin
        cnt_q[b] <= '0;
      end
    end else begin
      sync1_q  <= bus.btn_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      for (int b = 0; b < 4; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
    end
  end

  // Press-only pulses for cambiar and establecer
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_n_q <= 2'b11;
    end else begin
      sel_n_q <= ~press_s[3:2];
    end
  end

  // Repeat FSMs for incrementar/decrementar; holding both silences and re-arms them
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_n_q <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        tmr_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        rep_n_q[i] <= 1'b1;
        if (!stable_q[i]) begin
          state_q[i] <= IDLE;
          tmr_q[i]   <= '0;
        end else if (both_s) begin
          state_q[i] <= HOLD;
          tmr_q[i]   <= '0;
        end else begin
          case (state_q[i])
            IDLE: begin
              if (press_s[i]) begin
                rep_n_q[i] <= 1'b0;
                state_q[i] <= HOLD;
                tmr_q[i]   <= '0;
              end else begin
                state_q[i] <= IDLE;
                tmr_q[i]   <= '0;
              end
            end
            HOLD: begin
              if (tmr_q[i] == TW'(HOLD_EFF - 1)) begin
                rep_n_q[i] <= 1'b0;
                state_q[i] <= REPEAT;
                tmr_q[i]   <= '0;
              end else begin
                tmr_q[i] <= sat_inc(tmr_q[i]);
              end
            end
            REPEAT: begin
              if (tmr_q[i] == TW'(REP_EFF - 1)) begin
                rep_n_q[i] <= 1'b0;
                tmr_q[i]   <= '0;
              end else begin
                tmr_q[i] <= sat_inc(tmr_q[i]);
              end
            end
            default: begin
              state_q[i] <= IDLE;
              tmr_q[i]   <= '0;
            end
          endcase
        end
      end
    end
  end

  assign bus.incrementar = rep_n_q[0];
  assign bus.decrementar = rep_n_q[1];
  assign bus.cambiar     = sel_n_q[0];
  assign bus.establecer  = sel_n_q[1];
  assign bus.pressed     = stable_q;

endmodule
